// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution multiply/accumulate path.
package conv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WIN_N  = 9;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } conv_state_e;

endpackage

// File: rtl/eight_bit_multiplier.sv
// Combinational unsigned DATA_W x DATA_W multiplier with a full-width product.
module eight_bit_multiplier #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);

    assign p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

endmodule

// File: rtl/conv_mult_feeder.sv
// Captures a pixel/weight window and streams one registered product per cycle
// to the accumulator, reusing a single multiplier across all window elements.
module conv_mult_feeder #(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned WIN_N  = conv_pkg::WIN_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [WIN_N*DATA_W-1:0] win_pix,
    input  logic [WIN_N*DATA_W-1:0] win_wgt,
    output logic [DATA_W-1:0]       prod_out,
    output logic                    prod_valid,
    output logic                    prod_last,
    output logic                    prod_ovf
);

    import conv_pkg::*;

    localparam int unsigned IDX_W = (WIN_N > 1) ? $clog2(WIN_N) : 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIN_N - 1);

    conv_state_e                  state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [WIN_N-1:0][DATA_W-1:0] pix_q, wgt_q;
    logic [2*DATA_W-1:0]          mult;
    logic                         handshake;
    logic                         at_last;

    assign at_last   = (idx_q == LastIdx);
    assign win_ready = (state_q == StIdle) || at_last;
    assign handshake = win_valid && win_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                // A new window arriving on the last element restarts without a bubble.
                if (handshake) begin
                    state_d = StRun;
                    idx_d   = '0;
                end else if (at_last) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q <= '0;
            wgt_q <= '0;
        end else if (handshake) begin
            pix_q <= win_pix;
            wgt_q <= win_wgt;
        end
    end

    eight_bit_multiplier #(
        .DATA_W (DATA_W)
    ) u_mult (
        .a (pix_q[idx_q]),
        .b (wgt_q[idx_q]),
        .p (mult)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_out   <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
            prod_ovf   <= 1'b0;
        end else if (state_q == StRun) begin
            prod_out   <= mult[DATA_W-1:0];
            prod_valid <= 1'b1;
            prod_last  <= at_last;
            prod_ovf   <= |mult[2*DATA_W-1:DATA_W];
        end else begin
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
            prod_ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_mult_feeder.sv
// Directed-vector bench for conv_mult_feeder with hand-computed products.
module tb_conv_mult_feeder;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WIN_N  = 9;

    logic                         clk;
    logic                         rst;
    logic                         win_valid;
    logic                         win_ready;
    logic [WIN_N-1:0][DATA_W-1:0] win_pix;
    logic [WIN_N-1:0][DATA_W-1:0] win_wgt;
    logic [DATA_W-1:0]            prod_out;
    logic                         prod_valid;
    logic                         prod_last;
    logic                         prod_ovf;

    int checks;
    int failures;

    conv_mult_feeder #(
        .DATA_W (DATA_W),
        .WIN_N  (WIN_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_pix    (win_pix),
        .win_wgt    (win_wgt),
        .prod_out   (prod_out),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ovf   (prod_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_prod(input string tag, input int v, input int o, input int l,
                              input int f);
        check_eq({tag, " valid"}, 32'(prod_valid), 32'(v));
        if (v != 0) check_eq({tag, " out"}, 32'(prod_out), 32'(o));
        check_eq({tag, " last"}, 32'(prod_last), 32'(l));
        check_eq({tag, " ovf"}, 32'(prod_ovf), 32'(f));
    endtask

    task automatic load(input int pix_base, input int pix_step, input int wgt_base,
                        input int wgt_step);
        for (int i = 0; i < int'(WIN_N); i++) begin
            win_pix[i] = 8'(pix_base + pix_step * i);
            win_wgt[i] = 8'(wgt_base + wgt_step * i);
        end
    endtask

    initial begin
        int nvalid;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        win_valid = 1'b0;
        win_pix   = '0;
        win_wgt   = '0;
        repeat (2) step();
        check_prod("reset", 0, 0, 0, 0);
        check_eq("reset out", 32'(prod_out), 0);
        rst = 1'b1;
        step();
        check_eq("ready after reset", 32'(win_ready), 1);

        // Single window: pix 2, wgt 1..9
        load(2, 0, 1, 1);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        check_eq("w1 ready idx0", 32'(win_ready), 0);
        check_eq("w1 no early valid", 32'(prod_valid), 0);
        for (int k = 0; k < 9; k++) begin
            step();
            check_prod($sformatf("w1 k%0d", k), 1, 2 * (k + 1), (k == 8) ? 1 : 0, 0);
            check_eq($sformatf("w1 ready k%0d", k), 32'(win_ready), (k >= 7) ? 1 : 0);
        end
        step();
        check_prod("w1 tail", 0, 0, 0, 0);
        check_eq("w1 out held", 32'(prod_out), 18);

        // Back-to-back: A = pix 1, B = pix 3, both wgt 1..9, valid held high
        load(1, 0, 1, 1);
        win_valid = 1'b1;
        step();
        load(3, 0, 1, 1);
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c == 9) win_valid = 1'b0;
            if (c <= 18)
                check_prod($sformatf("b2b c%0d", c), 1, (c <= 9) ? c : 3 * (c - 9),
                           (c == 9 || c == 18) ? 1 : 0, 0);
            else
                check_prod("b2b tail", 0, 0, 0, 0);
        end

        // Overflow on element 0; inputs scrambled right after acceptance
        win_pix    = '0;
        win_wgt    = '0;
        win_pix[0] = 8'd200;
        win_wgt[0] = 8'd2;
        win_valid  = 1'b1;
        step();
        win_valid = 1'b0;
        win_pix   = '1;
        win_wgt   = '1;
        for (int k = 0; k < 9; k++) begin
            step();
            check_prod($sformatf("ovf k%0d", k), 1, (k == 0) ? 144 : 0, (k == 8) ? 1 : 0,
                       (k == 0) ? 1 : 0);
        end

        // Valid pulse while not ready must be ignored
        load(1, 0, 5, 0);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        nvalid    = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 4) begin
                load(7, 0, 7, 0);
                win_valid = 1'b1;
            end
            step();
            if (c == 3) check_eq("ign ready idx3", 32'(win_ready), 0);
            if (c == 4) win_valid = 1'b0;
            if (prod_valid) nvalid++;
            if (c <= 9) check_eq($sformatf("ign out c%0d", c), 32'(prod_out), 5);
        end
        check_eq("ign count", 32'(nvalid), 9);

        // Asynchronous reset at idx 4
        load(1, 0, 1, 1);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        repeat (4) step();
        check_eq("rst pre out", 32'(prod_out), 4);
        #2;
        rst = 1'b0;
        #1;
        check_prod("rst async", 0, 0, 0, 0);
        check_eq("rst async out", 32'(prod_out), 0);
        #2;
        rst = 1'b1;
        step();
        check_eq("rst ready", 32'(win_ready), 1);
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            if (prod_valid) nvalid++;
            step();
        end
        check_eq("rst no products", 32'(nvalid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
